// File: rtl/led_drv_pkg.sv
// Shared types and default sizing for the LED shift-register driver.
// Build option LED_SHIFT_DRIVER_ACTIVE_LOW_EN is consumed by led_shift_driver.
package led_drv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } led_drv_state_t;

    localparam int LED_DRV_WIDTH   = 16;
    localparam int LED_DRV_CLK_DIV = 4;

endpackage

// File: rtl/led_shift_tick.sv
// Phase divider: one-cycle phase_end strobe every CLK_DIV enabled cycles,
// held at zero while disabled so every phase starts from a fresh count.
module led_shift_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phase_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;

    // Divider count wraps on the strobe, so back-to-back phases restart at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (!en) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign phase_end = en && (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/led_shift_driver.sv
// Serialises the LED bar onto a 74HC595-style chain whenever it changes.
// Define LED_SHIFT_DRIVER_ACTIVE_LOW_EN to drive inverted data (common-anode).
module led_shift_driver
    import led_drv_pkg::*;
#(
    parameter int WIDTH   = LED_DRV_WIDTH,
    parameter int CLK_DIV = LED_DRV_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] led_in,
    output logic             ser_clk,
    output logic             ser_data,
    output logic             ser_latch,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef LED_SHIFT_DRIVER_ACTIVE_LOW_EN
    localparam logic DATA_INV = 1'b1;
`else
    localparam logic DATA_INV = 1'b0;
`endif

    led_drv_state_t   state_r, state_nxt_s;
    logic [WIDTH-1:0] shift_r, shift_nxt_s;
    logic [WIDTH-1:0] sent_r, sent_nxt_s;
    logic             sent_valid_r, sent_valid_nxt_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
    logic             ser_clk_r, ser_clk_nxt_s;
    logic             ser_data_r, ser_data_nxt_s;
    logic             ser_latch_r, ser_latch_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             frame_done_r, frame_done_nxt_s;
    logic             phase_end_s;
    logic             start_s;
    logic             last_bit_s;

    led_shift_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_r != IDLE),
        .phase_end (phase_end_s)
    );

    // A lost sent_valid (after reset) forces a resend even of an unchanged bar.
    assign start_s    = !sent_valid_r || (led_in != sent_r);
    assign last_bit_s = (bit_cnt_r == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:     if (start_s)     state_nxt_s = SHIFT_LO; else state_nxt_s = IDLE;
            SHIFT_LO: if (phase_end_s) state_nxt_s = SHIFT_HI; else state_nxt_s = SHIFT_LO;
            SHIFT_HI: begin
                if (phase_end_s) begin
                    if (last_bit_s) state_nxt_s = LATCH; else state_nxt_s = SHIFT_LO;
                end else begin
                    state_nxt_s = SHIFT_HI;
                end
            end
            LATCH:    if (phase_end_s) state_nxt_s = IDLE; else state_nxt_s = LATCH;
            default:  state_nxt_s = IDLE;
        endcase
    end

    // Next values of the datapath and registered pins.
    always_comb begin
        shift_nxt_s      = shift_r;
        sent_nxt_s       = sent_r;
        sent_valid_nxt_s = sent_valid_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        ser_clk_nxt_s    = ser_clk_r;
        ser_data_nxt_s   = ser_data_r;
        ser_latch_nxt_s  = ser_latch_r;
        busy_nxt_s       = busy_r;
        frame_done_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    shift_nxt_s      = led_in;
                    sent_nxt_s       = led_in;
                    sent_valid_nxt_s = 1'b1;
                    bit_cnt_nxt_s    = {CNT_W{1'b0}};
                    ser_clk_nxt_s    = 1'b0;
                    ser_data_nxt_s   = led_in[WIDTH-1] ^ DATA_INV;
                    busy_nxt_s       = 1'b1;
                end else begin
                    busy_nxt_s       = 1'b0;
                end
            end
            SHIFT_LO: begin
                if (phase_end_s) ser_clk_nxt_s = 1'b1; else ser_clk_nxt_s = 1'b0;
            end
            SHIFT_HI: begin
                if (phase_end_s) begin
                    ser_clk_nxt_s = 1'b0;
                    if (last_bit_s) begin
                        ser_latch_nxt_s = 1'b1;
                    end else begin
                        shift_nxt_s    = {shift_r[WIDTH-2:0], 1'b0};
                        ser_data_nxt_s = shift_r[WIDTH-2] ^ DATA_INV;
                        bit_cnt_nxt_s  = bit_cnt_r + CNT_W'(1);
                    end
                end else begin
                    ser_clk_nxt_s = 1'b1;
                end
            end
            LATCH: begin
                if (phase_end_s) begin
                    ser_latch_nxt_s  = 1'b0;
                    busy_nxt_s       = 1'b0;
                    frame_done_nxt_s = 1'b1;
                end else begin
                    ser_latch_nxt_s  = 1'b1;
                end
            end
            default: begin
                ser_clk_nxt_s   = 1'b0;
                ser_latch_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // Datapath and output pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r      <= {WIDTH{1'b0}};
            sent_r       <= {WIDTH{1'b0}};
            sent_valid_r <= 1'b0;
            bit_cnt_r    <= {CNT_W{1'b0}};
            ser_clk_r    <= 1'b0;
            ser_data_r   <= 1'b0;
            ser_latch_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            shift_r      <= shift_nxt_s;
            sent_r       <= sent_nxt_s;
            sent_valid_r <= sent_valid_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            ser_clk_r    <= ser_clk_nxt_s;
            ser_data_r   <= ser_data_nxt_s;
            ser_latch_r  <= ser_latch_nxt_s;
            busy_r       <= busy_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    assign ser_clk    = ser_clk_r;
    assign ser_data   = ser_data_r;
    assign ser_latch  = ser_latch_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver with an external 74HC595 chain model.
module tb_led_shift_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] led_in;
    logic        ser_clk, ser_data, ser_latch, busy, frame_done;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    // external chain model and activity counters
    logic [15:0] cap     = 16'h0000;
    logic [15:0] latched = 16'h0000;
    int bits_seen = 0;
    int latch_cnt = 0;
    int busy_cyc  = 0;
    int latch_cyc = 0;
    int done_cnt  = 0;

    int s_bits, s_latch, s_busy, s_lcyc, s_done;

    led_shift_driver #(.WIDTH(16), .CLK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .led_in     (led_in),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_latch  (ser_latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge ser_clk) begin
        cap       <= {cap[14:0], ser_data};
        bits_seen <= bits_seen + 1;
    end

    always @(posedge ser_latch) begin
        latched   <= cap;
        latch_cnt <= latch_cnt + 1;
    end

    always @(posedge clk) begin
        if (busy === 1'b1)       busy_cyc  <= busy_cyc + 1;
        if (ser_latch === 1'b1)  latch_cyc <= latch_cyc + 1;
        if (frame_done === 1'b1) done_cnt  <= done_cnt + 1;
    end

    function automatic logic [15:0] board(input logic [15:0] v);
`ifdef LED_SHIFT_DRIVER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_bits  = bits_seen;
        s_latch = latch_cnt;
        s_busy  = busy_cyc;
        s_lcyc  = latch_cyc;
        s_done  = done_cnt;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] v);
        check({tag, "_word"},  32'(latched), 32'(board(v)));
        check({tag, "_bits"},  32'(bits_seen - s_bits), 32'd16);
        check({tag, "_latch"}, 32'(latch_cnt - s_latch), 32'd1);
        check({tag, "_done"},  32'(done_cnt - s_done), 32'd1);
        check({tag, "_busy"},  32'(busy_cyc - s_busy), 32'd132);
    endtask

    initial begin
        rst_n  = 1'b0;
        led_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ser_clk",    32'(ser_clk),    32'd0);
        check("rst_ser_data",   32'(ser_data),   32'd0);
        check("rst_ser_latch",  32'(ser_latch),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // first frame after reset even though led_in is zero
        snap();
        rst_n = 1'b1;
        @(negedge clk);
        check("start_latency", 32'(busy), 32'd1);
        wait_done("f0_timeout");
        @(negedge clk);
        check_frame("f0", 16'h0000);
        check("f0_latch_cycles", 32'(latch_cyc - s_lcyc), 32'd4);

        // bar at LED 5
        repeat (5) @(negedge clk);
        snap();
        led_in = 16'h001F;
        wait_done("f1_timeout");
        @(negedge clk);
        check_frame("f1", 16'h001F);

        // changes mid-frame: 0003 must be dropped, 0007 follows immediately
        repeat (3) @(negedge clk);
        snap();
        led_in = 16'h0001;
        @(negedge clk);
        check("f2_busy", 32'(busy), 32'd1);
        led_in = 16'h0003;
        @(negedge clk);
        led_in = 16'h0007;
        wait_done("f2_timeout");
        check("f2_word", 32'(latched), 32'(board(16'h0001)));
        check("f2_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("f3_back_to_back", 32'(busy), 32'd1);
        wait_done("f3_timeout");
        @(negedge clk);
        check("f3_word", 32'(latched), 32'(board(16'h0007)));
        check("f23_latches", 32'(latch_cnt - s_latch), 32'd2);
        check("f23_done", 32'(done_cnt - s_done), 32'd2);

        // reset around bit 8 of an all-ones frame
        repeat (3) @(negedge clk);
        led_in = 16'hFFFF;
        @(negedge clk);
        check("f4_busy", 32'(busy), 32'd1);
        repeat (66) @(negedge clk);
        snap();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",    32'(busy),      32'd0);
        check("mid_rst_ser_clk", 32'(ser_clk),   32'd0);
        check("mid_rst_data",    32'(ser_data),  32'd0);
        check("mid_rst_latch",   32'(ser_latch), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_latch", 32'(latch_cnt - s_latch), 32'd0);
        snap();
        rst_n = 1'b1;
        wait_done("f5_timeout");
        @(negedge clk);
        check_frame("f5", 16'hFFFF);

        // steady input: one frame, then silence
        repeat (2) @(negedge clk);
        snap();
        led_in = 16'hAAAA;
        repeat (1000) @(negedge clk);
        check("f6_word",  32'(latched), 32'(board(16'hAAAA)));
        check("f6_done",  32'(done_cnt - s_done), 32'd1);
        check("f6_latch", 32'(latch_cnt - s_latch), 32'd1);
        check("f6_bits",  32'(bits_seen - s_bits), 32'd16);
        check("f6_busy",  32'(busy_cyc - s_busy), 32'd132);
        check("f6_idle",  32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/led_shift_driver.md
# led_shift_driver

Downstream output stage for the bound flasher. Takes the 16-bit LED bar vector from the flasher and drives it serially onto an external shift-register chain (74HC595-style) using clock, data and latch pins. A new frame is sent automatically whenever the bar value differs from the last value latched. The block decouples the flasher's per-cycle LED updates from the slower serial board interface.

## Interface
- `WIDTH`, default 16: number of LED bits per frame, ≥2.
- `CLK_DIV`, default 4: system clocks per serial half-period, ≥1.
- `clk`, input, 1: system clock; all logic on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `led_in`, input, WIDTH: LED bar vector from the flasher; bit i drives LED i.
- `ser_clk`, output, 1: serial shift clock; the external register samples on its rising edge.
- `ser_data`, output, 1: serial data, MSB first.
- `ser_latch`, output, 1: storage-register latch pulse.
- `busy`, output, 1: a frame is in progress.
- `frame_done`, output, 1: one-cycle pulse when a frame has been latched.

## Operation
- State machine states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- Internal `sent` register, WIDTH bits, plus a `sent_valid` flag. Reset clears `sent_valid` to 0.
- **IDLE**
  - Start condition: `!sent_valid || led_in != sent`.
  - On start, at the same edge: `shift_reg <= led_in`, `sent <= led_in`, `sent_valid <= 1`, `ser_data <= led_in[WIDTH-1]`, `busy <= 1`, go to SHIFT_LO.
- **SHIFT_LO**
  - `ser_clk` = 0 for CLK_DIV cycles, then go to SHIFT_HI.
- **SHIFT_HI**
  - `ser_clk` = 1 for CLK_DIV cycles.
  - At the end of the phase, if `bit_cnt == WIDTH-1`: go to LATCH, `ser_clk <= 0`, `ser_latch <= 1`.
  - Otherwise: shift left, `ser_data <= next bit`, `bit_cnt++`, go to SHIFT_LO.
- **LATCH**
  - `ser_latch` = 1 for CLK_DIV cycles.
  - Then: `ser_latch <= 0`, `busy <= 0`, `frame_done <= 1` for one cycle, go to IDLE.
- `led_in` is sampled only in IDLE. Changes during a frame are ignored.
  - If the final value differs from `sent`, the next frame starts on the first IDLE cycle, which is the same cycle `frame_done` is high.
  - Intermediate values are dropped; only the latest value is sent.
- Counters:
  - Divider counter: `$clog2(CLK_DIV)` bits, minimum 1; it wraps at CLK_DIV-1.
  - Bit counter: `$clog2(WIDTH)` bits; it resets to 0 on frame start.
- All outputs are registered, with no combinational path from `led_in`.

## Timing
- Reset values: `ser_clk`=0, `ser_data`=0, `ser_latch`=0, `busy`=0, `frame_done`=0, state IDLE, `sent_valid`=0.
- Latency from mismatch seen in IDLE to `busy` high: 1 cycle.
- Frame length (`busy` high): 2·CLK_DIV·WIDTH + CLK_DIV cycles. With defaults: 132 cycles.
- `ser_data` is stable for CLK_DIV cycles before and CLK_DIV cycles after each `ser_clk` rising edge.
- Back-to-back frames: at most 1 IDLE cycle between frames, namely the `frame_done` cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately.
  - No latch pulse is produced for the partial frame.
  - After release, the current `led_in` is sent as the first frame, even if it equals the previous value.
- Constant `led_in` after the first frame: no further activity.

## Configuration
- Macro: `LED_SHIFT_DRIVER_ACTIVE_LOW_EN`.
- Defined: `ser_data` carries the inverted bit, for common-anode boards where 0 lights the LED. `sent` and the change detection still use the true `led_in` value.
- Undefined: `ser_data` carries `led_in` bits unmodified.
- In both cases the reset value of `ser_data` is 0.

## Structure
- Package `led_drv_pkg`:
  - state enum `led_drv_state_t`
  - default constants `LED_DRV_WIDTH`=16 and `LED_DRV_CLK_DIV`=4
- Sub-module `led_shift_tick`: parameterised divider producing a one-cycle `phase_end` strobe every CLK_DIV cycles while enabled. It restarts from 0 on each phase entry.

## Test plan
- Reset release with `led_in`=16'h0000 → one frame is still sent: 16 zero bits, `ser_latch` high 4 cycles, `busy` high 132 cycles, `frame_done` pulse.
- After idle, `led_in`=16'h001F (flasher at LED 5) → `ser_data` sequence is 11 zeros then 5 ones, sampled at `ser_clk` rising edges; external model captures 16'h001F.
- `led_in` steps 16'h0001 → 16'h0003 → 16'h0007 on consecutive cycles mid-frame → current frame completes unchanged; next frame (16'h0007) starts in the `frame_done` cycle; 16'h0003 is never sent.
- `rst_n` pulsed low at bit 8 of a 16'hFFFF frame → outputs 0 immediately, no latch; after release a full 16'hFFFF frame is sent.
- `led_in` held at 16'hAAAA for 1000 cycles after its frame → exactly one frame and one `frame_done`.
- With `LED_SHIFT_DRIVER_ACTIVE_LOW_EN` defined, `led_in`=16'h00FF → external model captures 16'hFF00.
